// File: rtl/vga_timing_ctrl.sv
// VGA 640x480@60 timing controller: line/frame counters, pixel requests issued ahead of
// the display, and re-alignment of returned pixel data with hsync, vsync and data-enable.
module vga_timing_ctrl #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned PIX_LAT = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic [15:0] pix_data,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb
);

  localparam logic [9:0] HSyncEnd  = 10'(H_SYNC);
  localparam logic [9:0] HActStart = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HActEnd   = 10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VSyncEnd  = 10'(V_SYNC);
  localparam logic [9:0] VActStart = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VActEnd   = 10'(V_SYNC + V_BACK + V_DISP);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam int unsigned LastStage = PIX_LAT - 1;

  logic [9:0]         h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic               req_q, req_d, fs_q, fs_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic               raw_hs_q, raw_hs_d, raw_vs_q, raw_vs_d;
  logic [PIX_LAT-1:0] hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, de_pipe_q, de_pipe_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [15:0]        rgb_q, rgb_d;
  logic               h_act, v_act, h_wrap;

  always_comb begin
    h_act  = (h_cnt_q >= HActStart) && (h_cnt_q < HActEnd);
    v_act  = (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd);
    h_wrap = (h_cnt_q == HLast);

    h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == VLast) ? 10'd0 : v_cnt_q + 10'd1;
    end

    req_d    = h_act && v_act;
    x_d      = req_d ? h_cnt_q - HActStart : 10'd0;
    y_d      = req_d ? v_cnt_q - VActStart : 10'd0;
    fs_d     = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    raw_hs_d = (h_cnt_q >= HSyncEnd);
    raw_vs_d = (v_cnt_q >= VSyncEnd);

    // Control bits wait PIX_LAT clocks so they meet the data returned by the source.
    hs_pipe_d = PIX_LAT'({hs_pipe_q, raw_hs_q});
    vs_pipe_d = PIX_LAT'({vs_pipe_q, raw_vs_q});
    de_pipe_d = PIX_LAT'({de_pipe_q, req_q});

    hs_d  = hs_pipe_q[LastStage];
    vs_d  = vs_pipe_q[LastStage];
    de_d  = de_pipe_q[LastStage];
    rgb_d = de_pipe_q[LastStage] ? pix_data : 16'h0;

    // Disabling flushes everything so a restart begins a clean frame.
    if (!en) begin
      h_cnt_d   = 10'd0;
      v_cnt_d   = 10'd0;
      req_d     = 1'b0;
      x_d       = 10'd0;
      y_d       = 10'd0;
      fs_d      = 1'b0;
      raw_hs_d  = 1'b1;
      raw_vs_d  = 1'b1;
      hs_pipe_d = '1;
      vs_pipe_d = '1;
      de_pipe_d = '0;
      hs_d      = 1'b1;
      vs_d      = 1'b1;
      de_d      = 1'b0;
      rgb_d     = 16'h0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      req_q     <= 1'b0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      fs_q      <= 1'b0;
      raw_hs_q  <= 1'b1;
      raw_vs_q  <= 1'b1;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
      de_pipe_q <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      de_q      <= 1'b0;
      rgb_q     <= 16'h0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      req_q     <= req_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      raw_hs_q  <= raw_hs_d;
      raw_vs_q  <= raw_vs_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      de_pipe_q <= de_pipe_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      rgb_q     <= rgb_d;
    end
  end

  assign pix_req     = req_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign frame_start = fs_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign vga_rgb     = rgb_q;

endmodule
